// File: rtl/vend_pkg.sv
// Shared constants for the coin-credit vending controller: FSM state
// encodings, accepted coin codes and a coin legality helper.
package vend_pkg;

   // FSM state encodings; 2'b11 is unused and recovers to COLLECT.
   localparam logic [1:0] COLLECT = 2'b00;
   localparam logic [1:0] VEND    = 2'b01;
   localparam logic [1:0] CHANGE  = 2'b10;

   // Coin codes the front end may present on coin_val.
   localparam logic [1:0] COIN_1 = 2'd1;
   localparam logic [1:0] COIN_2 = 2'd2;

   // A coin is accepted only when it carries one of the known denominations.
   function automatic logic coin_is_legal(input logic [1:0] val);
      return (val == COIN_1) || (val == COIN_2);
   endfunction

endpackage

// File: rtl/vend_change_ctrl_if.sv
// Coin front end <-> vending controller signal bundle.
// master: front end / stimulus side; slave: the controller.
interface vend_change_ctrl_if #(
   parameter int CREDIT_W = 3
);
   logic                coin_valid;
   logic [1:0]          coin_val;
   logic                cancel;
   logic [CREDIT_W-1:0] credit;
   logic                dispense;
   logic                change_pulse;
   logic                coin_reject;
   logic                busy;

   modport master (
      output coin_valid, coin_val, cancel,
      input  credit, dispense, change_pulse, coin_reject, busy
   );

   modport slave (
      input  coin_valid, coin_val, cancel,
      output credit, dispense, change_pulse, coin_reject, busy
   );
endinterface

// File: rtl/vend_change_ctrl_credit_counter.sv
// Credit register: up/down counter with add-coin, subtract-price and
// decrement-by-one controls. Clear has top priority, then subtract,
// decrement and add; the FSM never requests more than one at a time.
module credit_counter #(
   parameter int PRICE    = 5,
   parameter int CREDIT_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                add_en_i,
   input  logic [1:0]          add_val_i,
   input  logic                sub_price_en_i,
   input  logic                dec_en_i,
   output logic [CREDIT_W-1:0] count_o
);
   localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

   logic [CREDIT_W-1:0] count_q;
   logic [CREDIT_W-1:0] count_d;

   // Select the next credit value from the single active control.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {CREDIT_W{1'b0}};
      end else if (sub_price_en_i) begin
         count_d = count_q - PRICE_W;
      end else if (dec_en_i) begin
         count_d = count_q - CREDIT_W'(1);
      end else if (add_en_i) begin
         count_d = count_q + CREDIT_W'(add_val_i);
      end else begin
         count_d = count_q;
      end
   end

   // Credit storage, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {CREDIT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/vend_change_ctrl.sv
// Coin-credit vending controller. Collects coins into the credit counter,
// releases an item for one cycle once credit reaches PRICE, then pays any
// remainder (or a cancelled credit) back as back-to-back change pulses.
module vend_change_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE    = 5,
   parameter int CREDIT_W = 3
) (
   input logic             clk,
   input logic             rst,
   vend_change_ctrl_if.slave bus
);
   // Credit peaks at PRICE+1 (PRICE-1 plus a 2-unit coin) and must not wrap.
   if ((PRICE < 1) || (PRICE > (2 ** CREDIT_W) - 2)) begin : g_bad_price
      $error("vend_change_ctrl: PRICE must lie in 1..2**CREDIT_W-2");
   end

   localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
   localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic                reject_q;
   logic                reject_d;
   logic [CREDIT_W-1:0] credit_s;
   logic [CREDIT_W:0]   sum_s;
   logic                coin_ok_s;
   logic                add_en_s;
   logic                sub_en_s;
   logic                dec_en_s;
   logic                clr_s;

   assign coin_ok_s = bus.coin_valid && coin_is_legal(bus.coin_val);
   assign sum_s     = {1'b0, credit_s} + (CREDIT_W + 1)'(bus.coin_val);

   // Next-state and counter-control decode; coins are only taken in COLLECT.
   always_comb begin
      state_d  = state_q;
      reject_d = 1'b0;
      add_en_s = 1'b0;
      sub_en_s = 1'b0;
      dec_en_s = 1'b0;
      clr_s    = 1'b0;
      case (state_q)
         COLLECT: begin
            if (coin_ok_s) begin
               add_en_s = 1'b1;
               // Coin is counted before cancel is considered: vend wins.
               if (sum_s >= PRICE_X) begin
                  state_d = VEND;
               end else if (bus.cancel) begin
                  state_d = CHANGE;
               end else begin
                  state_d = COLLECT;
               end
            end else begin
               reject_d = bus.coin_valid;
               if (bus.cancel && (credit_s != {CREDIT_W{1'b0}})) begin
                  state_d = CHANGE;
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         VEND: begin
            reject_d = bus.coin_valid;
            sub_en_s = 1'b1;
            if (credit_s > PRICE_W) begin
               state_d = CHANGE;
            end else begin
               state_d = COLLECT;
            end
         end
         CHANGE: begin
            reject_d = bus.coin_valid;
            dec_en_s = (credit_s != {CREDIT_W{1'b0}});
            if (credit_s > CREDIT_W'(1)) begin
               state_d = CHANGE;
            end else begin
               state_d = COLLECT;
            end
         end
         default: begin
            clr_s   = 1'b1;
            state_d = COLLECT;
         end
      endcase
   end

   // State and coin-reject registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= COLLECT;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         reject_q <= reject_d;
      end
   end

   credit_counter #(
      .PRICE    (PRICE),
      .CREDIT_W (CREDIT_W)
   ) u_credit (
      .clk            (clk),
      .rst            (rst),
      .clr_i          (clr_s),
      .add_en_i       (add_en_s),
      .add_val_i      (bus.coin_val),
      .sub_price_en_i (sub_en_s),
      .dec_en_i       (dec_en_s),
      .count_o        (credit_s)
   );

   // Actuator outputs come straight from the state register.
   assign bus.credit       = credit_s;
   assign bus.dispense     = (state_q == VEND);
   assign bus.change_pulse = (state_q == CHANGE);
   assign bus.busy         = (state_q == VEND) || (state_q == CHANGE);
   assign bus.coin_reject  = reject_q;
endmodule

// File: doc/vend_change_ctrl.md
Name: vend_change_ctrl

Overview:
Coin-credit vending controller that pairs with the team's up/down mod-N counter work. Credit is counted up on coin insertion and counted down when change is paid out, one unit per cycle. The block accepts coins, dispenses an item once credit reaches PRICE, and returns change or cancelled credit as a train of single-cycle pulses. It sits between the coin/button front end and the dispenser/change-hopper actuators.

Parameters:
PRICE, 5, item price in credit units; legal range 1..(2**CREDIT_W - 2)
CREDIT_W, 3, credit register width; PRICE+1 must fit in CREDIT_W bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
coin_valid  input  1  one-cycle strobe: coin present on coin_val
coin_val  input  2  coin value in units; legal values are 1 and 2; 0 and 3 are illegal
cancel  input  1  level/strobe request to refund all credit
credit  output  CREDIT_W  current credit in units
dispense  output  1  one-cycle item release pulse
change_pulse  output  1  one unit of change returned this cycle
coin_reject  output  1  registered one-cycle pulse: the previous cycle's coin was refused
busy  output  1  high in VEND and CHANGE

Behaviour:
- Reset (async, any state, mid-payout included): state=COLLECT, credit=0, dispense=0, change_pulse=0, coin_reject=0, busy=0. No partial pulse is emitted after reset release.
- States: COLLECT, VEND, CHANGE. dispense=(state==VEND), change_pulse=(state==CHANGE), busy=dispense|change_pulse. All three are decoded from the state register only and do not depend on inputs combinationally.
- COLLECT, legal coin: credit <= credit+coin_val. If the sum >= PRICE, next state is VEND. Otherwise, if cancel is high, next state is CHANGE. Otherwise remain in COLLECT.
- COLLECT, illegal coin_val (0 or 3) with coin_valid: credit unchanged, coin_reject=1 in the next cycle. cancel is still evaluated in the same cycle.
- COLLECT, cancel with no coin: go to CHANGE if credit>0; if credit==0, ignore.
- Simultaneous coin+cancel: the coin is added first. Vend wins if the threshold is reached; otherwise the full new credit is refunded.
- VEND (exactly 1 cycle): credit <= credit-PRICE. Next state is CHANGE if the remainder is >0, else COLLECT.
- CHANGE: credit decrements by 1 each cycle. Exit to COLLECT on the cycle where credit goes 1->0, so the number of change_pulse cycles equals the credit on entry.
- In VEND/CHANGE: any coin_valid is rejected (coin_reject the next cycle, credit untouched); cancel is ignored.
- Arithmetic: credit never exceeds PRICE+1 (maximum is PRICE-1+2), so no wrap occurs. Subtraction never underflows because of the state guards. An elaboration-time check enforces the PRICE/CREDIT_W constraint.
- Latency: coin at edge N reaching the threshold gives dispense high in cycle N..N+1. Change pulses follow back to back from N+1.

Decomposition:
- Package vend_pkg holds:
  - state encoding constants: COLLECT=2'b00, VEND=2'b01, CHANGE=2'b10 (2'b11 is illegal and recovers to COLLECT with credit cleared)
  - coin code constants: COIN_1=2'd1, COIN_2=2'd2
- One sub-module, credit_counter: a CREDIT_W up/down counter with add-value, subtract-PRICE and decrement-by-1 controls, and an async active-high clear. The FSM in vend_change_ctrl drives its controls.

Test Plan:
- PRICE=5: coins 2,2,1 on separate cycles -> credit 2,4,5; dispense 1 cycle; credit 0; no change_pulse; back to COLLECT.
- Credit 4, coin 2 -> credit 6, dispense 1 cycle, credit 1, exactly one change_pulse, credit 0, COLLECT.
- Credit 3, cancel -> three consecutive change_pulse cycles, credit 3->2->1->0, dispense never asserted.
- coin_val=3 in COLLECT -> coin_reject one cycle later, credit unchanged. Coin 1 during CHANGE -> rejected, pulse count unchanged.
- Credit 2, coin 2 + cancel in the same cycle -> credit 4, four change_pulses. Credit 3, coin 2 + cancel -> dispense, then no change.
- rst asserted during the second change_pulse of a 3-unit refund -> outputs 0 immediately; after release credit=0 and state is COLLECT.
